// File: rtl/gate_truth_table_sequencer.sv
// rtl/gate_truth_table_sequencer.sv - drives a 2-input gate through all four vectors and checks its truth table
module gate_truth_table_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] expected,
    output logic       gate_a,
    output logic       gate_b,
    input  logic       gate_y,
    output logic       busy,
    output logic       done,
    output logic [3:0] truth_table,
    output logic       pass,
    output logic [3:0] fail_mask
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRIVE   = 3'd1,
        SETTLE  = 3'd2,
        CAPTURE = 3'd3,
        REPORT  = 3'd4
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    state_t     state, state_n;
    logic [1:0] idx, idx_n;
    logic [3:0] settle_cnt, settle_cnt_n;
    logic [3:0] exp_q, exp_n;
    logic [3:0] table_n;
    logic       pass_n;
    logic [3:0] fail_mask_n;

    always_comb begin
        state_n      = state;
        idx_n        = idx;
        settle_cnt_n = settle_cnt;
        exp_n        = exp_q;
        table_n      = truth_table;
        pass_n       = pass;
        fail_mask_n  = fail_mask;

        if (state != IDLE && abort) begin
            // The partial table is kept so the aborted run can still be inspected.
            state_n      = IDLE;
            idx_n        = 2'd0;
            settle_cnt_n = 4'd0;
            pass_n       = 1'b0;
            fail_mask_n  = 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        exp_n       = expected;
                        table_n     = 4'd0;
                        pass_n      = 1'b0;
                        fail_mask_n = 4'd0;
                        idx_n       = 2'd0;
                        state_n     = DRIVE;
                    end
                end
                DRIVE: begin
                    settle_cnt_n = SETTLE_LOAD;
                    state_n      = (SETTLE_CYCLES == 0) ? CAPTURE : SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt <= 4'd1) begin
                        settle_cnt_n = 4'd0;
                        state_n      = CAPTURE;
                    end else begin
                        settle_cnt_n = settle_cnt - 4'd1;
                    end
                end
                CAPTURE: begin
                    table_n[idx] = gate_y;
                    if (idx == 2'd3) begin
                        // Verdict is computed from the final table so it lines up with done.
                        pass_n      = (table_n == exp_q);
                        fail_mask_n = table_n ^ exp_q;
                        state_n     = REPORT;
                    end else begin
                        idx_n   = idx + 2'd1;
                        state_n = DRIVE;
                    end
                end
                REPORT: begin
                    idx_n   = 2'd0;
                    state_n = IDLE;
                end
                default: begin
                    idx_n   = 2'd0;
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= 2'd0;
            settle_cnt  <= 4'd0;
            exp_q       <= 4'd0;
            truth_table <= 4'd0;
            pass        <= 1'b0;
            fail_mask   <= 4'd0;
            gate_a      <= 1'b0;
            gate_b      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            settle_cnt  <= settle_cnt_n;
            exp_q       <= exp_n;
            truth_table <= table_n;
            pass        <= pass_n;
            fail_mask   <= fail_mask_n;
            // Gate pins follow the vector of the state being entered, so they are stable for all of DRIVE.
            gate_a      <= (state_n != IDLE) ? idx_n[1] : 1'b0;
            gate_b      <= (state_n != IDLE) ? idx_n[0] : 1'b0;
            busy        <= (state_n != IDLE);
            done        <= (state_n == REPORT);
        end
    end

endmodule
